// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer gain sequencer.
// ramp_toward() is the per-band slew step used when ramping is built in.
package eq_pkg;

  localparam int unsigned NUM_BANDS = 3;
  localparam int unsigned GAIN_W = 8;
  localparam logic [GAIN_W-1:0] DEFAULT_GAIN = 8'd32;

  typedef logic [1:0]        band_t;
  typedef logic [GAIN_W-1:0] gain_t;

  typedef struct packed {
    band_t band;
    gain_t gain;
  } gain_cmd_t;

  typedef enum logic [1:0] {IDLE, DRAIN, HOLD} seq_state_t;

  // One extra bit of headroom so neither end of the gain range can wrap.
  function automatic gain_t ramp_toward(gain_t cur, gain_t tgt, logic [GAIN_W:0] step);
    logic [GAIN_W:0] c;
    logic [GAIN_W:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) begin
      if ((t - c) <= step) return tgt;
      return gain_t'(c + step);
    end
    if ((c - t) <= step) return tgt;
    return gain_t'(c - step);
  endfunction

endpackage

// File: rtl/gain_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module gain_cmd_fifo
  import eq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  gain_cmd_t din,
  output gain_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  gain_cmd_t   mem_q [DEPTH];

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Buffers band/gain commands and applies them to the live gains on sample ticks.
// Define GAIN_RAMP_EN to slew each gain by at most RAMP_STEP per tick.
module eq_gain_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAMP_STEP  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_band,
  input  logic [GAIN_W-1:0] cmd_gain,
  output logic [GAIN_W-1:0] gain [0:NUM_BANDS-1],
  output logic              ramping,
  output logic [7:0]        drop_cnt
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      RAMP_STEP < 1 || RAMP_STEP > (2 ** GAIN_W) - 1) begin : gen_param_check
    $error("eq_gain_sequencer: illegal FIFO_DEPTH or RAMP_STEP");
  end

  seq_state_t state_q, state_d;
  gain_cmd_t  fifo_din, fifo_dout;
  logic       fifo_full, fifo_empty;
  logic       push, pop, pop_band_ok;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic [7:0] drop_q, drop_d;
  gain_t      target_q [NUM_BANDS];
  gain_t      gain_q   [NUM_BANDS];
  gain_t      gain_d   [NUM_BANDS];

  assign push      = cmd_valid && !fifo_full;
  assign cmd_ready = !fifo_full;
  assign fifo_din  = '{band: cmd_band, gain: cmd_gain};

  gain_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A pop that lands on a tick is deferred (HOLD) so a target write never
  // shares an edge with a gain update.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (push) state_d = DRAIN;
      end
      DRAIN, HOLD: begin
        if (fifo_empty) begin
          state_d = push ? DRAIN : IDLE;
        end else if (sample_tick) begin
          state_d = HOLD;
        end else begin
          pop     = 1'b1;
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_band_ok = (fifo_dout.band < band_t'(NUM_BANDS));

  always_comb begin
    drop_inc = {1'b0, cmd_valid && fifo_full} + {1'b0, pop && !pop_band_ok};
    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      gain_d[b] = gain_q[b];
      if (sample_tick) begin
`ifdef GAIN_RAMP_EN
        gain_d[b] = ramp_toward(gain_q[b], target_q[b], (GAIN_W + 1)'(RAMP_STEP));
`else
        gain_d[b] = target_q[b];
`endif
      end
    end
  end

  always_comb begin
    ramping = 1'b0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      ramping = ramping | (gain_q[b] != target_q[b]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drop_q  <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        target_q[b] <= DEFAULT_GAIN;
        gain_q[b]   <= DEFAULT_GAIN;
      end
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      for (int b = 0; b < NUM_BANDS; b++) begin
        gain_q[b] <= gain_d[b];
        if (pop && fifo_dout.band == band_t'(b)) target_q[b] <= fifo_dout.gain;
      end
    end
  end

  assign gain     = gain_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Randomized and directed bench for eq_gain_sequencer against a queue-based model.
// Follows the GAIN_RAMP_EN setting of the build.
module tb_eq_gain_sequencer;

  localparam int NB    = 3;
  localparam int DEF   = 32;
  localparam int STEP  = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_band;
  logic [7:0] cmd_gain;
  logic [7:0] gain [0:NB-1];
  logic       ramping;
  logic [7:0] drop_cnt;

  eq_gain_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_band    (cmd_band),
    .cmd_gain    (cmd_gain),
    .gain        (gain),
    .ramping     (ramping),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending commands, targets, applied gains, drops.
  int m_tgt [NB];
  int m_gain[NB];
  int m_drop;
  int q_band[$];
  int q_gain[$];

  logic [33:0] obs_vec;
  assign obs_vec = {gain[2], gain[1], gain[0], ramping, drop_cnt, cmd_ready};

  localparam logic [33:0] RESET_VEC = {8'd32, 8'd32, 8'd32, 1'b0, 8'd0, 1'b1};

  function automatic int ramp(int g, int t);
`ifdef GAIN_RAMP_EN
    if (t - g <= STEP && g - t <= STEP) return t;
    return (t > g) ? g + STEP : g - STEP;
`else
    return t;
`endif
  endfunction

  function automatic logic [33:0] expect_vec();
    logic r = 1'b0;
    for (int i = 0; i < NB; i++) r = r | (m_gain[i] != m_tgt[i]);
    return {8'(m_gain[2]), 8'(m_gain[1]), 8'(m_gain[0]), r, 8'(m_drop),
            q_band.size() < DEPTH};
  endfunction

  task automatic model_reset();
    q_band.delete();
    q_gain.delete();
    m_drop = 0;
    for (int i = 0; i < NB; i++) begin
      m_tgt[i]  = DEF;
      m_gain[i] = DEF;
    end
  endtask

  // One clock edge of the specified behaviour: a pending command is taken
  // unless a tick is being applied, in which case it waits.
  task automatic model_edge(bit v, int b, int g, bit t);
    bit full  = q_band.size() >= DEPTH;
    bit popit = q_band.size() > 0 && !t;
    int drops = 0;
    if (v && full) drops++;
    if (t) for (int i = 0; i < NB; i++) m_gain[i] = ramp(m_gain[i], m_tgt[i]);
    if (popit) begin
      int pb = q_band.pop_front();
      int pg = q_gain.pop_front();
      if (pb < NB) m_tgt[pb] = pg;
      else drops++;
    end
    if (v && !full) begin
      q_band.push_back(b);
      q_gain.push_back(g);
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  task automatic cyc(bit v, int b, int g, bit t);
    cmd_valid   = v;
    cmd_band    = 2'(b);
    cmd_gain    = 8'(g);
    sample_tick = t;
    @(posedge clk);
    model_edge(v, b, g, t);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    sample_tick = 1'b0;
    cmd_band    = '0;
    cmd_gain    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec !== RESET_VEC) begin
        bad++;
        $display("FAIL reset_idle[%0d]: actual=%h required=%h", k, obs_vec, RESET_VEC);
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_ramp_band1();
`ifdef GAIN_RAMP_EN
    int exp_g[4] = '{35, 38, 40, 40};
    bit exp_r[4] = '{1, 1, 0, 0};
`else
    int exp_g[4] = '{40, 40, 40, 40};
    bit exp_r[4] = '{0, 0, 0, 0};
`endif
    do_reset();
    cyc(1, 1, 40, 0);
    cyc(0, 0, 0, 0);
    total++;
    if (gain[1] !== 8'd32 || ramping !== 1'b1) begin
      bad++;
      $display("FAIL ramp_target_set: actual gain1=%0d ramping=%b required gain1=32 ramping=1",
               gain[1], ramping);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1);
      total++;
      if (gain[1] !== 8'(exp_g[k]) || ramping !== exp_r[k] || obs_vec !== expect_vec()) begin
        bad++;
        $display("FAIL ramp_tick[%0d]: actual gain1=%0d ramping=%b vec=%h required gain1=%0d ramping=%b vec=%h",
                 k, gain[1], ramping, obs_vec, exp_g[k], exp_r[k], expect_vec());
      end
    end
  endtask

  task automatic test_apply_latency();
    do_reset();
    cyc(1, 2, 200, 0);
    total++;
    if (ramping !== 1'b0 || gain[2] !== 8'd32) begin
      bad++;
      $display("FAIL latency_push_edge: actual ramping=%b gain2=%0d required ramping=0 gain2=32",
               ramping, gain[2]);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      total++;
      if (ramping !== 1'b1 || gain[2] !== 8'd32) begin
        bad++;
        $display("FAIL latency_wait[%0d]: actual ramping=%b gain2=%0d required ramping=1 gain2=32",
                 k, ramping, gain[2]);
      end
    end
    cyc(0, 0, 0, 1);
    total++;
`ifdef GAIN_RAMP_EN
    if (gain[2] !== 8'd35) begin
`else
    if (gain[2] !== 8'd200) begin
`endif
      bad++;
      $display("FAIL latency_apply: actual gain2=%0d vec=%h required vec=%h",
               gain[2], obs_vec, expect_vec());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, i % 3, 50 + i * 10, 1);
      total++;
      if (cmd_ready !== (i < 3) || obs_vec !== expect_vec()) begin
        bad++;
        $display("FAIL overflow[%0d]: actual ready=%b vec=%h required ready=%b vec=%h",
                 i, cmd_ready, obs_vec, i < 3, expect_vec());
      end
    end
    total++;
    if (drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL overflow_drops: actual=%0d required=2", drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, i >= 5);
      total++;
      if (obs_vec !== expect_vec()) begin
        bad++;
        $display("FAIL overflow_drain[%0d]: actual=%h required=%h", i, obs_vec, expect_vec());
      end
    end
  endtask

  task automatic test_invalid_band();
    do_reset();
    cyc(1, 3, 99, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    total++;
    if (obs_vec !== {8'd32, 8'd32, 8'd32, 1'b0, 8'd1, 1'b1}) begin
      bad++;
      $display("FAIL invalid_band: actual=%h required=%h", obs_vec,
               {8'd32, 8'd32, 8'd32, 1'b0, 8'd1, 1'b1});
    end
  endtask

  task automatic test_same_band();
    do_reset();
    cyc(1, 0, 10, 0);
    cyc(1, 0, 50, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    total++;
`ifdef GAIN_RAMP_EN
    if (gain[0] !== 8'd35 || obs_vec !== expect_vec()) begin
`else
    if (gain[0] !== 8'd50 || obs_vec !== expect_vec()) begin
`endif
      bad++;
      $display("FAIL same_band: actual gain0=%0d vec=%h required vec=%h",
               gain[0], obs_vec, expect_vec());
    end
  endtask

  task automatic test_double_drop();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 3, i, 1);
    cyc(1, 0, 77, 0);
    total++;
    if (drop_cnt !== 8'd2 || obs_vec !== expect_vec()) begin
      bad++;
      $display("FAIL double_drop: actual drop=%0d vec=%h required drop=2 vec=%h",
               drop_cnt, obs_vec, expect_vec());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, $urandom_range(0, 2), $urandom_range(0, 255), 1);
      total++;
      if (obs_vec !== expect_vec()) begin
        bad++;
        $display("FAIL saturate[%0d]: actual=%h required=%h", i, obs_vec, expect_vec());
      end
    end
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL saturate_final: actual=%0d required=255", drop_cnt);
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    cyc(1, 1, 200, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_async: actual=%h required=%h", obs_vec, RESET_VEC);
    end
    cmd_valid   = 1'b0;
    sample_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, k == 2);
      total++;
      if (obs_vec !== RESET_VEC) begin
        bad++;
        $display("FAIL reset_fifo_empty[%0d]: actual=%h required=%h", k, obs_vec, RESET_VEC);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
          $urandom_range(0, 3) == 0);
      total++;
      if (obs_vec !== expect_vec()) begin
        bad++;
        $display("FAIL random[%0d]: actual=%h required=%h", i, obs_vec, expect_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_band1();
    test_apply_latency();
    test_overflow();
    test_invalid_band();
    test_same_band();
    test_double_drop();
    test_saturation();
    test_reset_mid_ramp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
